shift_stepper: RTL and testbench
================================

SHIFT_STEPPER -- requirements
Module: shift_stepper

Interface
REQ-001 Parameter: TICK_DIV, default 4, clock cycles per shift step (legal range 1..255).
REQ-002 Parameter: WIDTH, default 5, data width of operand and result.
REQ-003 clk  input  1  single clock; all logic on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  single-cycle request to begin a stepped shift; sampled only in IDLE.
REQ-006 operand  input  5  value to shift; latched on accepted start.
REQ-007 dir  input  1  1 = right shift, 0 = left shift; latched on accepted start.
REQ-008 target  input  3  final shift distance 0..7; latched on accepted start.
REQ-009 sh_in  output  5  operand driven to the downstream combinational shifter.
REQ-010 sh_distance  output  3  current step distance driven to the shifter.
REQ-011 sh_direction  output  1  latched dir driven to the shifter.
REQ-012 sh_out  input  5  combinational shifter result for sh_in/sh_distance/sh_direction.
REQ-013 result  output  5  registered shifter result from the most recent step.
REQ-014 busy  output  1  high while in RUN.
REQ-015 done  output  1  one-cycle pulse after final result is captured.

Function
REQ-016 The FSM SHALL have three states: IDLE, RUN, DONE.
REQ-017 IDLE: start=1 SHALL latch operand/dir/target, clear sh_distance and prescaler to 0, and enter RUN next cycle; start=0 SHALL hold IDLE.
REQ-018 RUN: the prescaler SHALL count 0..TICK_DIV-1, incrementing once per cycle.
REQ-019 RUN, prescaler==TICK_DIV-1: result SHALL load sh_out that same edge and the prescaler SHALL wrap to 0.
REQ-020 At that edge, if sh_distance==latched target, the FSM SHALL enter DONE; otherwise sh_distance SHALL increment by 1.
REQ-021 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-022 Timing: with start accepted in cycle 0, the final capture SHALL occur at the end of cycle (target+1)*TICK_DIV, with done high in cycle (target+1)*TICK_DIV+1.
REQ-023 sh_distance SHALL never exceed the latched target and SHALL never wrap past 7.
REQ-024 Distances >= WIDTH SHALL pass through unchanged, since the shifter result is 0 for those; no special-casing is permitted.
REQ-025 target=0 SHALL produce a single step with result=operand after TICK_DIV cycles.
REQ-026 start during RUN or DONE SHALL be ignored, and latched values SHALL NOT change.
REQ-027 result SHALL hold its value in IDLE until the next capture.
REQ-028 sh_in and sh_direction SHALL remain stable from the accepted start until the next accepted start.

Reset
REQ-029 rst=1 SHALL force IDLE, with sh_in, sh_distance, sh_direction, result, prescaler and latched target all 0, and busy=0, done=0.
REQ-030 rst asserted mid-RUN or in DONE SHALL abort without a done pulse and take priority over start in the same cycle.
REQ-031 The first start SHALL be accepted in the cycle after rst deasserts.

Structure
REQ-032 A shared package/include SHALL hold the state encodings (IDLE/RUN/DONE), WIDTH=5 and distance width 3.
REQ-033 The prescaler SHALL be one sub-module, tick_gen (parameter TICK_DIV; inputs clk, rst, clear, enable; output tick at count TICK_DIV-1).
REQ-034 The combinational shifter SHALL stay external and SHALL NOT be duplicated inside this block.

Verification
REQ-035 TICK_DIV=4, operand=00111, dir=0, target=2, start at cycle 0 -> result sequence 00111, 01110, 11100; done only at cycle 13; busy cycles 1..12.
REQ-036 operand=11111, dir=1, target=7 -> final result 00000, done at cycle 33; sh_distance runs 0..7 with no wrap.
REQ-037 operand=10101, target=0 -> result=10101, done at cycle 5, sh_distance stays 0.
REQ-038 start pulsed again at cycle 6 of a target=2 run with different operand/dir -> ignored; sh_in, sh_direction and final result are unchanged.
REQ-039 rst at cycle 7 of a target=3 run -> next cycle IDLE, all outputs 0, no done pulse; a new start at cycle 9 completes normally.
REQ-040 TICK_DIV=1, operand=00001, dir=0, target=4 -> result changes every cycle to 10000, done at cycle 6.

Source files
------------

// File: rtl/shift_stepper_pkg.sv
// Shared definitions for the stepped shifter controller: state encoding and
// default data / distance widths.
package shift_stepper_pkg;

  localparam int SHIFT_WIDTH = 5;
  localparam int DIST_W      = 3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/shift_stepper_tick_gen.sv
// Prescaler: counts 0..TICK_DIV-1 while enabled and flags the last count so
// the controller can take one shift step per TICK_DIV cycles.
module tick_gen #(
  parameter int TICK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  assign tick = (count_q == LAST);

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = tick ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/shift_stepper.sv
// Steps an external combinational shifter from distance 0 up to a latched
// target, one step per TICK_DIV cycles, registering each shifter result.
module shift_stepper
  import shift_stepper_pkg::*;
#(
  parameter int TICK_DIV = 4,
  parameter int WIDTH    = SHIFT_WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [WIDTH-1:0]  operand,
  input  logic              dir,
  input  logic [DIST_W-1:0] target,
  output logic [WIDTH-1:0]  sh_in,
  output logic [DIST_W-1:0] sh_distance,
  output logic              sh_direction,
  input  logic [WIDTH-1:0]  sh_out,
  output logic [WIDTH-1:0]  result,
  output logic              busy,
  output logic              done,
  output state_e            state_o
);

  // Handshake: start is a one-cycle request that is taken only in IDLE;
  // while busy or done is high the block is not ready and start is dropped.
  state_e              state_q, state_d;
  logic [WIDTH-1:0]    operand_q, operand_d;
  logic                dir_q, dir_d;
  logic [DIST_W-1:0]   target_q, target_d;
  logic [DIST_W-1:0]   dist_q, dist_d;
  logic [WIDTH-1:0]    result_q, result_d;
  logic                tick;

  tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk    (clk),
    .rst    (rst),
    .clear  (state_q != S_RUN),
    .enable (state_q == S_RUN),
    .tick   (tick)
  );

  always_comb begin
    state_d   = state_q;
    operand_d = operand_q;
    dir_d     = dir_q;
    target_d  = target_q;
    dist_d    = dist_q;
    result_d  = result_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          operand_d = operand;
          dir_d     = dir;
          target_d  = target;
          dist_d    = '0;
          state_d   = S_RUN;
        end
      end
      S_RUN: begin
        if (tick) begin
          result_d = sh_out;
          // Stop at the target so the distance never runs past it or wraps.
          if (dist_q == target_q) begin
            state_d = S_DONE;
          end else begin
            dist_d = dist_q + 1'b1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      operand_q <= '0;
      dir_q     <= 1'b0;
      target_q  <= '0;
      dist_q    <= '0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      operand_q <= operand_d;
      dir_q     <= dir_d;
      target_q  <= target_d;
      dist_q    <= dist_d;
      result_q  <= result_d;
    end
  end

  assign sh_in        = operand_q;
  assign sh_distance  = dist_q;
  assign sh_direction = dir_q;
  assign result       = result_q;
  assign busy         = (state_q == S_RUN);
  assign done         = (state_q == S_DONE);
  assign state_o      = state_q;

endmodule

// File: tb/tb_shift_stepper.sv
// Directed bench for shift_stepper: a TICK_DIV=4 instance driven from a vector
// table plus corner sequences, and a TICK_DIV=1 instance.
module tb_shift_stepper;
  import shift_stepper_pkg::*;

  // Clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // Instance A: TICK_DIV = 4
  logic       a_start, a_dir, a_sh_dir, a_busy, a_done;
  logic [4:0] a_operand, a_sh_in, a_sh_out, a_result;
  logic [2:0] a_target, a_sh_dist;
  state_e     a_state;

  // Instance B: TICK_DIV = 1
  logic       b_start, b_dir, b_sh_dir, b_busy, b_done;
  logic [4:0] b_operand, b_sh_in, b_sh_out, b_result;
  logic [2:0] b_target, b_sh_dist;
  state_e     b_state;

  // External combinational shifters
  assign a_sh_out = a_sh_dir ? (a_sh_in >> a_sh_dist) : (a_sh_in << a_sh_dist);
  assign b_sh_out = b_sh_dir ? (b_sh_in >> b_sh_dist) : (b_sh_in << b_sh_dist);

  shift_stepper #(.TICK_DIV(4), .WIDTH(5)) dut_a (
    .clk(clk), .rst(rst), .start(a_start), .operand(a_operand), .dir(a_dir),
    .target(a_target), .sh_in(a_sh_in), .sh_distance(a_sh_dist),
    .sh_direction(a_sh_dir), .sh_out(a_sh_out), .result(a_result),
    .busy(a_busy), .done(a_done), .state_o(a_state)
  );

  shift_stepper #(.TICK_DIV(1), .WIDTH(5)) dut_b (
    .clk(clk), .rst(rst), .start(b_start), .operand(b_operand), .dir(b_dir),
    .target(b_target), .sh_in(b_sh_in), .sh_distance(b_sh_dist),
    .sh_direction(b_sh_dir), .sh_out(b_sh_out), .result(b_result),
    .busy(b_busy), .done(b_done), .state_o(b_state)
  );

  // Scoreboard counters
  int pass_cnt = 0;
  int chk_cnt  = 0;

  // Per-run observations gathered by run_a
  logic [4:0] res_log [0:63];
  int         done_cyc, busy_cnt, busy_first, busy_last, max_dist;
  logic       in_ok, dist_ok;
  logic [4:0] final_res;

  typedef struct {
    logic [4:0] op;
    logic       dir;
    logic [2:0] tgt;
    logic [4:0] exp_res;
    int         exp_done;
    int         exp_busy;
  } vec_t;
  vec_t vecs [7];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Start is high in cycle 0; cycle c is observed just after the c-th edge.
  task automatic run_a(input logic [4:0] op, input logic d, input logic [2:0] t,
                       input int ignore_at, input logic [4:0] op2, input logic d2);
    done_cyc = -1; busy_cnt = 0; busy_first = -1; busy_last = -1; max_dist = 0;
    in_ok = 1'b1; dist_ok = 1'b1; final_res = '0;
    a_operand = op; a_dir = d; a_target = t; a_start = 1'b1;
    for (int c = 1; c < 64; c++) begin
      step();
      a_start = (c == ignore_at);
      if (c == ignore_at) begin
        a_operand = op2; a_dir = d2; a_target = 3'd7;
      end
      res_log[c] = a_result;
      if (a_busy) begin
        busy_cnt++;
        if (busy_first < 0) busy_first = c;
        busy_last = c;
      end
      if (a_sh_in != op || a_sh_dir != d) in_ok = 1'b0;
      if (a_sh_dist > t) dist_ok = 1'b0;
      if (int'(a_sh_dist) > max_dist) max_dist = int'(a_sh_dist);
      if (a_done) begin
        done_cyc  = c;
        final_res = a_result;
        break;
      end
    end
    a_start = 1'b0;
    step();
  endtask

  initial begin
    int         bdone;
    logic [4:0] blog [0:15];
    logic [4:0] exp_b [2:6];
    logic       early_done;

    vecs[0] = '{5'b00111, 1'b0, 3'd2, 5'b11100, 13, 12};
    vecs[1] = '{5'b11111, 1'b1, 3'd7, 5'b00000, 33, 32};
    vecs[2] = '{5'b10101, 1'b0, 3'd0, 5'b10101,  5,  4};
    vecs[3] = '{5'b00011, 1'b1, 3'd1, 5'b00001,  9,  8};
    vecs[4] = '{5'b01001, 1'b0, 3'd3, 5'b01000, 17, 16};
    vecs[5] = '{5'b10000, 1'b1, 3'd4, 5'b00001, 21, 20};
    vecs[6] = '{5'b00001, 1'b0, 3'd5, 5'b00000, 25, 24};
    exp_b[2] = 5'b00001; exp_b[3] = 5'b00010; exp_b[4] = 5'b00100;
    exp_b[5] = 5'b01000; exp_b[6] = 5'b10000;

    rst = 1'b1;
    a_start = 1'b0; a_operand = '0; a_dir = 1'b0; a_target = '0;
    b_start = 1'b0; b_operand = '0; b_dir = 1'b0; b_target = '0;
    repeat (3) step();

    // Reset state
    check("rst_state",  int'(a_state), int'(S_IDLE));
    check("rst_sh_in",  int'(a_sh_in), 0);
    check("rst_dist",   int'(a_sh_dist), 0);
    check("rst_dir",    int'(a_sh_dir), 0);
    check("rst_result", int'(a_result), 0);
    check("rst_busy",   int'(a_busy), 0);
    check("rst_done",   int'(a_done), 0);

    rst = 1'b0;
    step();

    // Result sequence for 00111 << 0,1,2 with TICK_DIV=4
    run_a(5'b00111, 1'b0, 3'd2, -1, 5'b0, 1'b0);
    check("seq_res_c5",  int'(res_log[5]),  int'(5'b00111));
    check("seq_res_c9",  int'(res_log[9]),  int'(5'b01110));
    check("seq_res_c13", int'(res_log[13]), int'(5'b11100));
    check("seq_done",    done_cyc, 13);
    check("seq_busy_first", busy_first, 1);
    check("seq_busy_last",  busy_last, 12);
    repeat (3) step();
    check("idle_hold_result", int'(a_result), int'(5'b11100));
    check("idle_busy",        int'(a_busy), 0);

    // Table of complete transactions
    for (int i = 0; i < 7; i++) begin
      run_a(vecs[i].op, vecs[i].dir, vecs[i].tgt, -1, 5'b0, 1'b0);
      check($sformatf("v%0d_done_cycle", i), done_cyc, vecs[i].exp_done);
      check($sformatf("v%0d_result", i), int'(final_res), int'(vecs[i].exp_res));
      check($sformatf("v%0d_busy_cycles", i), busy_cnt, vecs[i].exp_busy);
      check($sformatf("v%0d_max_dist", i), max_dist, int'(vecs[i].tgt));
      check($sformatf("v%0d_sh_in_stable", i), int'(in_ok), 1);
      check($sformatf("v%0d_dist_bound", i), int'(dist_ok), 1);
      step();
    end

    // Start pulsed mid-run with other operand/dir is ignored
    run_a(5'b00110, 1'b0, 3'd2, 6, 5'b11001, 1'b1);
    check("ign_done_cycle", done_cyc, 13);
    check("ign_result",     int'(final_res), int'(5'b11000));
    check("ign_sh_in",      int'(in_ok), 1);
    check("ign_busy",       busy_cnt, 12);
    a_operand = '0; a_dir = 1'b0; a_target = '0;
    step();

    // Reset at cycle 7 of a target=3 run, with start asserted alongside
    early_done = 1'b0;
    a_operand = 5'b10110; a_dir = 1'b1; a_target = 3'd3; a_start = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      step();
      a_start = 1'b0;
      if (a_done) early_done = 1'b1;
    end
    check("abort_busy_before", int'(a_busy), 1);
    rst = 1'b1; a_start = 1'b1;
    step();
    rst = 1'b0; a_start = 1'b0;
    check("abort_state",  int'(a_state), int'(S_IDLE));
    check("abort_busy",   int'(a_busy), 0);
    check("abort_done",   int'(a_done | early_done), 0);
    check("abort_result", int'(a_result), 0);
    check("abort_sh_in",  int'(a_sh_in), 0);
    check("abort_dist",   int'(a_sh_dist), 0);
    check("abort_dir",    int'(a_sh_dir), 0);
    step();
    check("abort_no_restart", int'(a_busy), 0);
    run_a(5'b01100, 1'b1, 3'd1, -1, 5'b0, 1'b0);
    check("post_abort_done",   done_cyc, 9);
    check("post_abort_result", int'(final_res), int'(5'b00110));

    // TICK_DIV=1: one step per cycle
    bdone = -1;
    b_operand = 5'b00001; b_dir = 1'b0; b_target = 3'd4; b_start = 1'b1;
    for (int c = 1; c < 16; c++) begin
      step();
      b_start = 1'b0;
      blog[c] = b_result;
      if (b_done && bdone < 0) bdone = c;
    end
    for (int c = 2; c <= 6; c++) begin
      check($sformatf("td1_res_c%0d", c), int'(blog[c]), int'(exp_b[c]));
    end
    check("td1_done_cycle", bdone, 6);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
